// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified-memory arbiter: FSM encodings, port ids and counter width.
package mem_arb_pkg;

    localparam int unsigned CNT_W = 4;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t RESP   = 2'd2;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational two-port winner selection: single requester wins, ties go to the CPU
// under fixed priority, otherwise to the port that was not granted last.
module arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       cpu_priority,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = PORT_CPU;
        if (req == 2'b11) begin
            winner = cpu_priority ? PORT_CPU : ~last_gnt;
        end else if (req[1]) begin
            winner = PORT_DMA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port fixed-latency instruction/data memory.
// Each transaction runs IDLE -> ACCESS (MEM_LAT cycles) -> RESP (one-cycle ack).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MEM_LAT      = 2,
    parameter int unsigned CPU_PRIORITY = 0
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Req0,
    input  logic          We0,
    input  logic [AW-1:0] Addr0,
    input  logic [DW-1:0] WData0,
    output logic          Ack0,
    output logic [DW-1:0] RData0,
    output logic          Gnt0,
    input  logic          Req1,
    input  logic          We1,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] WData1,
    output logic          Ack1,
    output logic [DW-1:0] RData1,
    output logic          Gnt1,
    output logic          MemEn,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gnt_id_q, gnt_id_d;
    logic               last_gnt_q, last_gnt_d;
    logic               we_q, we_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [DW-1:0]      rdata0_q, rdata0_d;
    logic [DW-1:0]      rdata1_q, rdata1_d;

    logic               pick_valid;
    logic               pick_winner;
    logic               in_access;
    logic               in_resp;

    arb_rr_pick u_pick (
        .req          ({Req1, Req0}),
        .last_gnt     (last_gnt_q),
        .cpu_priority (CPU_PRIORITY != 0),
        .valid        (pick_valid),
        .winner       (pick_winner)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_id_d   = gnt_id_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = ACCESS;
                    gnt_id_d   = pick_winner;
                    last_gnt_d = pick_winner;
                    cnt_d      = CNT_W'(MEM_LAT - 1);
                    // Latch the request so the memory side is immune to requester churn.
                    if (pick_winner == PORT_DMA) begin
                        we_d    = We1;
                        addr_d  = Addr1;
                        wdata_d = WData1;
                    end else begin
                        we_d    = We0;
                        addr_d  = Addr0;
                        wdata_d = WData0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (gnt_id_q == PORT_DMA) begin
                            rdata1_d = MemRData;
                        end else begin
                            rdata0_d = MemRData;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gnt_id_q   <= PORT_CPU;
            last_gnt_q <= PORT_DMA;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_id_q   <= gnt_id_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // All outputs decode registered state only; no Req-to-output path.
    always_comb begin
        in_access = (state_q == ACCESS);
        in_resp   = (state_q == RESP);
        MemEn     = in_access;
        MemWe     = in_access & we_q;
        MemAddr   = in_access ? addr_q : '0;
        MemWData  = in_access ? wdata_q : '0;
        Gnt0      = (in_access | in_resp) & (gnt_id_q == PORT_CPU);
        Gnt1      = (in_access | in_resp) & (gnt_id_q == PORT_DMA);
        Ack0      = in_resp & (gnt_id_q == PORT_CPU);
        Ack1      = in_resp & (gnt_id_q == PORT_DMA);
        RData0    = rdata0_q;
        RData1    = rdata1_q;
    end

endmodule
